cl_axil_reg_bank: RTL and testbench



---
 rtl/cl_axil_reg_bank.sv | 177 +++++++++++++++++
 tb/tb_cl_axil_reg_bank.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_axil_reg_bank.sv
// AXI4-Lite slave register bank: NUM_RW strobed RW registers (optional byte-swapped
// readback) and NUM_RO fabric status registers, with SLVERR on undecoded/RO writes.
module cl_axil_reg_bank #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'h0000_0500,
  parameter int                    NUM_RW       = 4,
  parameter int                    NUM_RO       = 2,
  parameter logic [31:0]           RESET_VALUE  = 32'h0,
  parameter logic [NUM_RW-1:0]     SWAP_MASK    = 'h1,
  parameter logic [31:0]           UNIMPL_VALUE = 32'hDEAD_BEEF
) (
  input  logic                                  clk_main_a0,
  input  logic                                  rst_main_n,
  input  logic                                  s_axil_awvalid,
  output logic                                  s_axil_awready,
  input  logic [ADDR_WIDTH-1:0]                 s_axil_awaddr,
  input  logic                                  s_axil_wvalid,
  output logic                                  s_axil_wready,
  input  logic [31:0]                           s_axil_wdata,
  input  logic [3:0]                            s_axil_wstrb,
  output logic                                  s_axil_bvalid,
  input  logic                                  s_axil_bready,
  output logic [1:0]                            s_axil_bresp,
  input  logic                                  s_axil_arvalid,
  output logic                                  s_axil_arready,
  input  logic [ADDR_WIDTH-1:0]                 s_axil_araddr,
  output logic                                  s_axil_rvalid,
  input  logic                                  s_axil_rready,
  output logic [31:0]                           s_axil_rdata,
  output logic [1:0]                            s_axil_rresp,
  output logic [NUM_RW*32-1:0]                  reg_q,
  output logic [NUM_RW-1:0]                     reg_wr_pulse,
  input  logic [((NUM_RO>0)?NUM_RO:1)*32-1:0]   status_in
);
  localparam logic [1:0] RESP_OK = 2'b00, RESP_SLVERR = 2'b10;

  logic                          rdy_q, rdy_d;
  logic                          aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0]         aw_addr_q, aw_addr_d, rd_addr_q, rd_addr_d;
  logic [31:0]                   w_data_q, w_data_d, rdata_q, rdata_d;
  logic [3:0]                    w_strb_q, w_strb_d;
  logic                          bvalid_q, bvalid_d, rvalid_q, rvalid_d, rd_pend_q, rd_pend_d;
  logic [1:0]                    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [NUM_RW-1:0][31:0]       regs_q, regs_d;
  logic [NUM_RW-1:0]             pulse_q, pulse_d;
  logic [ADDR_WIDTH-1:0]         widx, ridx;

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // rdy_q keeps every ready low through reset and for the edge that releases it
  assign s_axil_awready = rdy_q && !aw_full_q && !bvalid_q;
  assign s_axil_wready  = rdy_q && !w_full_q && !bvalid_q;
  assign s_axil_arready = rdy_q && !rd_pend_q && !rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign reg_q          = regs_q;
  assign reg_wr_pulse   = pulse_q;

  always_comb begin
    rdy_d     = 1'b1;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    widx      = (aw_addr_q - BASE_ADDR) >> 2;
    ridx      = (rd_addr_q - BASE_ADDR) >> 2;

    if (s_axil_awvalid && s_axil_awready) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axil_awaddr;
    end
    if (s_axil_wvalid && s_axil_wready) begin
      w_full_d = 1'b1;
      w_data_d = s_axil_wdata;
      w_strb_d = s_axil_wstrb;
    end
    if (aw_full_q && w_full_q) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_SLVERR;
      if (aw_addr_q >= BASE_ADDR) begin
        for (int i = 0; i < NUM_RW; i++) begin
          if (widx == ADDR_WIDTH'(i)) begin
            bresp_d    = RESP_OK;
            pulse_d[i] = 1'b1;
            for (int k = 0; k < 4; k++)
              if (w_strb_q[k]) regs_d[i][8*k +: 8] = w_data_q[8*k +: 8];
          end
        end
      end
    end
    if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;

    if (s_axil_arvalid && s_axil_arready) begin
      rd_pend_d = 1'b1;
      rd_addr_d = s_axil_araddr;
    end
    // regs_q is the pre-commit value, so a same-edge write is not visible here
    if (rd_pend_q) begin
      rd_pend_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = UNIMPL_VALUE;
      rresp_d   = RESP_SLVERR;
      if (rd_addr_q >= BASE_ADDR) begin
        for (int i = 0; i < NUM_RW; i++) begin
          if (ridx == ADDR_WIDTH'(i)) begin
            rdata_d = SWAP_MASK[i] ? swap32(regs_q[i]) : regs_q[i];
            rresp_d = RESP_OK;
          end
        end
        for (int j = 0; j < NUM_RO; j++) begin
          if (ridx == ADDR_WIDTH'(NUM_RW + j)) begin
            rdata_d = status_in[32*j +: 32];
            rresp_d = RESP_OK;
          end
        end
      end
    end
    if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rresp_d  = '0;
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      rdy_q     <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      regs_q    <= {NUM_RW{RESET_VALUE}};
      pulse_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      rdy_q     <= rdy_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end
endmodule

// File: tb/tb_cl_axil_reg_bank.sv
// Scoreboard bench for cl_axil_reg_bank: expected B/R responses are queued at drive
// time from a small register model and popped when the DUT responds.
module tb_cl_axil_reg_bank;
  localparam int          NUM_RW = 4;
  localparam int          NUM_RO = 2;
  localparam logic [31:0] BASE   = 32'h0000_0500;
  localparam logic [31:0] RSTV   = 32'h0;
  localparam logic [3:0]  SWAP   = 4'h1;
  localparam logic [31:0] UNIMPL = 32'hDEAD_BEEF;

  typedef struct { logic [1:0] resp; logic [NUM_RW-1:0] pulse; } b_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;
  logic [NUM_RW*32-1:0] reg_q;
  logic [NUM_RW-1:0] reg_wr_pulse;
  logic [31:0] status [NUM_RO];
  logic [NUM_RO*32-1:0] status_in;
  logic [31:0] mdl [NUM_RW];
  b_exp_t bq[$];
  r_exp_t rq[$];
  int vectors = 0, miscompares = 0;

  assign status_in = {status[1], status[0]};
  always #5 clk = ~clk;

  cl_axil_reg_bank #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO),
    .RESET_VALUE(RSTV), .SWAP_MASK(SWAP), .UNIMPL_VALUE(UNIMPL)) dut (
    .clk_main_a0(clk), .rst_main_n(rst_n),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
    .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .status_in(status_in));

  function automatic logic [NUM_RW*32-1:0] mdl_packed();
    logic [NUM_RW*32-1:0] p;
    for (int i = 0; i < NUM_RW; i++) p[32*i +: 32] = mdl[i];
    return p;
  endfunction

  function automatic r_exp_t exp_rd(input logic [31:0] a);
    r_exp_t e;
    logic [31:0] idx, v;
    e.data = UNIMPL; e.resp = 2'b10;
    if (a >= BASE) begin
      idx = (a - BASE) >> 2;
      if (idx < NUM_RW) begin
        v = mdl[idx];
        e.data = SWAP[idx] ? {v[7:0], v[15:8], v[23:16], v[31:24]} : v;
        e.resp = 2'b00;
      end else if (idx < NUM_RW + NUM_RO) begin
        e.data = status[idx - NUM_RW];
        e.resp = 2'b00;
      end
    end
    return e;
  endfunction

  // queues the expected B response and applies the write to the model
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    b_exp_t e;
    logic [31:0] idx;
    e.resp = 2'b10; e.pulse = '0;
    if (a >= BASE) begin
      idx = (a - BASE) >> 2;
      if (idx < NUM_RW) begin
        e.resp = 2'b00; e.pulse[idx] = 1'b1;
        for (int k = 0; k < 4; k++) if (s[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
      end
    end
    bq.push_back(e);
  endtask

  task automatic timeout(input string nm);
    vectors++; miscompares++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic do_aw(input logic [31:0] a);
    int n = 0;
    awaddr = a; awvalid = 1;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) timeout("aw_hs");
    @(negedge clk); awvalid = 0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    if (!wready) timeout("w_hs");
    @(negedge clk); wvalid = 0;
  endtask

  task automatic wait_b(input string nm, input bit chk_lat);
    int n = 0;
    b_exp_t e;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin timeout(nm); return; end
    e = bq.pop_front();
    vectors++;
    if (bresp !== e.resp || reg_wr_pulse !== e.pulse) begin
      miscompares++;
      $display("FAIL %s: bresp=%b pulse=%b, required bresp=%b pulse=%b", nm, bresp, reg_wr_pulse, e.resp, e.pulse);
    end
    if (chk_lat) begin
      vectors++;
      if (n !== 1) begin miscompares++; $display("FAIL %s_lat: bvalid after %0d, required 1", nm, n); end
    end
    @(negedge clk);
    vectors++;
    if (bvalid !== 1'b0 || reg_wr_pulse !== '0 || reg_q !== mdl_packed()) begin
      miscompares++;
      $display("FAIL %s_after: bvalid=%b pulse=%b reg_q=%h, required 0 0 %h", nm, bvalid, reg_wr_pulse, reg_q, mdl_packed());
    end
  endtask

  // mode 0: AW+W same cycle, 1: W three cycles ahead of AW, 2: AW ahead of W
  task automatic write_reg(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int mode);
    int n = 0;
    push_wr(a, d, s);
    if (mode == 1) begin
      do_w(d, s); repeat (2) @(negedge clk); do_aw(a);
    end else if (mode == 2) begin
      do_aw(a); repeat (2) @(negedge clk); do_w(d, s);
    end else begin
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
      if (!(awready && wready)) timeout("aw_w_hs");
      @(negedge clk); awvalid = 0; wvalid = 0;
    end
    wait_b(nm, mode == 0);
  endtask

  task automatic read_reg(input string nm, input logic [31:0] a);
    int n = 0;
    r_exp_t e;
    rq.push_back(exp_rd(a));
    araddr = a; arvalid = 1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) timeout("ar_hs");
    @(negedge clk); arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) begin timeout(nm); return; end
    e = rq.pop_front();
    vectors++;
    if (rdata !== e.data || rresp !== e.resp || n !== 1) begin
      miscompares++;
      $display("FAIL %s: rdata=%h rresp=%b lat=%0d, required %h %b lat=1", nm, rdata, rresp, n, e.data, e.resp);
    end
    @(negedge clk);
    vectors++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || rresp !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_clear: rvalid=%b rdata=%h rresp=%b, required 0 0 0", nm, rvalid, rdata, rresp);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NUM_RW; i++) mdl[i] = RSTV;
    repeat (3) @(negedge clk);
    vectors++;
    if (awready !== 0 || wready !== 0 || arready !== 0 || bvalid !== 0 || rvalid !== 0 ||
        reg_q !== {NUM_RW{RSTV}} || rdata !== 0 || reg_wr_pulse !== 0) begin
      miscompares++;
      $display("FAIL reset_hold: rdy=%b%b%b bv=%b rv=%b reg_q=%h rdata=%h, required 000 0 0 %h 0",
               awready, wready, arready, bvalid, rvalid, reg_q, rdata, {NUM_RW{RSTV}});
    end
    rst_n = 1;
    @(negedge clk);
    vectors++;
    if (awready !== 1 || wready !== 1 || arready !== 1 || bvalid !== 0 || rvalid !== 0) begin
      miscompares++;
      $display("FAIL reset_release: rdy=%b%b%b bv=%b rv=%b, required 111 0 0", awready, wready, arready, bvalid, rvalid);
    end
  endtask

  task automatic test_w_before_aw();
    write_reg("w_first_wr0", BASE, 32'h1234_5678, 4'hF, 1);
    read_reg("rd_swap0", BASE);
    write_reg("aw_first_wr1", BASE + 4, 32'h1234_5678, 4'hF, 2);
    read_reg("rd_noswap1", BASE + 4);
  endtask

  task automatic test_strobes();
    write_reg("strb_ff", BASE + 4, 32'hFFFF_FFFF, 4'hF, 0);
    write_reg("strb_0101", BASE + 4, 32'h0, 4'b0101, 0);
    read_reg("rd_strb", BASE + 4);
    write_reg("strb_none", BASE + 4, 32'h0, 4'b0000, 0);
    read_reg("rd_strb_none", BASE + 4);
  endtask

  task automatic test_ro_errors();
    read_reg("rd_ro0", BASE + 4 * NUM_RW);
    read_reg("rd_ro1", BASE + 4 * NUM_RW + 4);
    write_reg("wr_ro0", BASE + 4 * NUM_RW, 32'h1111_2222, 4'hF, 0);
    read_reg("rd_ro0_again", BASE + 4 * NUM_RW);
    read_reg("rd_below", BASE - 4);
    read_reg("rd_above", BASE + 4 * (NUM_RW + NUM_RO));
    write_reg("wr_above", BASE + 4 * (NUM_RW + NUM_RO), 32'h3, 4'hF, 0);
  endtask

  task automatic test_concurrency();
    int n = 0;
    b_exp_t eb;
    r_exp_t er;
    write_reg("conc_init", BASE + 8, 32'hA, 4'hF, 0);
    rq.push_back(exp_rd(BASE + 8));
    push_wr(BASE + 8, 32'hB, 4'hF);
    awaddr = BASE + 8; wdata = 32'hB; wstrb = 4'hF; araddr = BASE + 8;
    awvalid = 1; wvalid = 1; arvalid = 1;
    while (!(awready && wready && arready) && n < 50) begin @(negedge clk); n++; end
    if (!(awready && wready && arready)) timeout("conc_hs");
    @(negedge clk); awvalid = 0; wvalid = 0; arvalid = 0;
    n = 0;
    while (!(bvalid && rvalid) && n < 50) begin @(negedge clk); n++; end
    if (!(bvalid && rvalid)) timeout("conc_resp");
    else begin
      eb = bq.pop_front(); er = rq.pop_front();
      vectors++;
      if (rdata !== er.data || rresp !== er.resp || bresp !== eb.resp || reg_wr_pulse !== eb.pulse) begin
        miscompares++;
        $display("FAIL conc_same_edge: rdata=%h bresp=%b pulse=%b, required %h %b %b",
                 rdata, bresp, reg_wr_pulse, er.data, eb.resp, eb.pulse);
      end
    end
    @(negedge clk);
    read_reg("conc_after", BASE + 8);
  endtask

  task automatic test_back_pressure();
    int n = 0;
    b_exp_t eb;
    r_exp_t er;
    bready = 0; rready = 0;
    rq.push_back(exp_rd(BASE));
    push_wr(BASE + 12, 32'hC0DE_000C, 4'hF);
    eb = bq[0]; er = rq[0];
    awaddr = BASE + 12; wdata = 32'hC0DE_000C; wstrb = 4'hF; araddr = BASE;
    awvalid = 1; wvalid = 1; arvalid = 1;
    while (!(awready && wready && arready) && n < 50) begin @(negedge clk); n++; end
    if (!(awready && wready && arready)) timeout("bp_hs");
    @(negedge clk); awvalid = 0; wvalid = 0; arvalid = 0;
    n = 0;
    while (!(bvalid && rvalid) && n < 50) begin @(negedge clk); n++; end
    if (!(bvalid && rvalid)) timeout("bp_resp");
    vectors++;
    if (reg_wr_pulse !== eb.pulse) begin
      miscompares++; $display("FAIL bp_pulse: pulse=%b, required %b", reg_wr_pulse, eb.pulse);
    end
    awaddr = BASE + 4; araddr = BASE + 4; awvalid = 1; wvalid = 1; arvalid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (bvalid !== 1 || rvalid !== 1 || bresp !== eb.resp || rdata !== er.data || rresp !== er.resp ||
          awready !== 0 || wready !== 0 || arready !== 0 || reg_wr_pulse !== 0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: bv=%b rv=%b bresp=%b rdata=%h rdy=%b%b%b pulse=%b, required 1 1 %b %h 000 0",
                 c, bvalid, rvalid, bresp, rdata, awready, wready, arready, reg_wr_pulse, eb.resp, er.data);
      end
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    eb = bq.pop_front(); er = rq.pop_front();
    bready = 1; rready = 1;
    @(negedge clk);
    vectors++;
    if (bvalid !== 0 || rvalid !== 0 || reg_q !== mdl_packed()) begin
      miscompares++;
      $display("FAIL bp_release: bv=%b rv=%b reg_q=%h, required 0 0 %h", bvalid, rvalid, reg_q, mdl_packed());
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_aw(BASE + 4);
    rst_n = 0;
    #1;
    vectors++;
    if (awready !== 0 || wready !== 0 || arready !== 0 || bvalid !== 0 || reg_q !== {NUM_RW{RSTV}}) begin
      miscompares++;
      $display("FAIL rst_mid: rdy=%b%b%b bv=%b reg_q=%h, required 000 0 %h", awready, wready, arready, bvalid, reg_q, {NUM_RW{RSTV}});
    end
    for (int i = 0; i < NUM_RW; i++) mdl[i] = RSTV;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (bvalid) seen++; end
    vectors++;
    if (seen != 0 || awready !== 1 || wready !== 1) begin
      miscompares++;
      $display("FAIL rst_mid_noresp: bvalid cycles=%0d rdy=%b%b, required 0 11", seen, awready, wready);
    end
    write_reg("rst_mid_wr", BASE + 4, 32'h55AA_33CC, 4'hF, 0);
    read_reg("rst_mid_rd", BASE + 4);
  endtask

  initial begin
    status[0] = 32'hCAFE_0001;
    status[1] = 32'h0BAD_F00D;
    test_reset();
    test_w_before_aw();
    test_strobes();
    test_ro_errors();
    test_concurrency();
    test_back_pressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule
